// File: rtl/lsu_bank_responder.sv
// Banked SRAM responder for one LSU: host preload, base-relative
// addressing and a two-cycle pipelined read return.
module lsu_bank_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int BANKS  = 4,
  parameter int DROP_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                run,
  input  logic                host_we,
  input  logic [1:0]          host_bank,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic                base_we,
  input  logic [1:0]          base_idx,
  input  logic [ADDR_W-1:0]   base_val,
  input  logic [2:0]          R_request,
  input  logic [DATA_W+2:0]   W_request,
  input  logic [ADDR_W+1:0]   LSU_addr_bus,
  output logic [DATA_W:0]     CBG_to_LSU_bus,
  output logic [1:0]          mode,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    RUN  = 2'd2
  } mode_e;

  mode_e mode_q, mode_d;

  logic [ADDR_W-1:0] base_q [BANKS];
  logic [DATA_W-1:0] mem_q  [BANKS][DEPTH];

  logic [DROP_W-1:0] drop_q, drop_d;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
  logic              out_vld_q;
  logic [DATA_W-1:0] out_dat_q;

  logic              ren, wen, run_act;
  logic [1:0]        r_sel, w_sel, addr_sel;
  logic [DATA_W-1:0] store_data;
  logic [ADDR_W-1:0] addr, ea;

  logic              mem_we;
  logic [1:0]        mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign ren        = R_request[0];
  assign r_sel      = R_request[2:1];
  assign store_data = W_request[DATA_W-1:0];
  assign wen        = W_request[DATA_W];
  assign w_sel      = W_request[DATA_W+2:DATA_W+1];
  assign addr       = LSU_addr_bus[ADDR_W-1:0];
  assign addr_sel   = LSU_addr_bus[ADDR_W+1:ADDR_W];

  // Carry out of the add is dropped, so addresses wrap within a bank.
  assign ea      = base_q[addr_sel] + addr;
  assign run_act = (mode_q == RUN);

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      IDLE, HOST: begin
        if (init)     mode_d = HOST;
        else if (run) mode_d = RUN;
      end
      RUN:     if (init) mode_d = HOST;
      default: mode_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (!run_act && (ren || wen) && !(&drop_q))
      drop_d = drop_q + 1'b1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_bank  = host_bank;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (run_act && wen) begin
      mem_we    = 1'b1;
      mem_bank  = w_sel;
      mem_addr  = ea;
      mem_wdata = store_data;
    end else if (mode_q == HOST && host_we) begin
      mem_we = 1'b1;
    end
  end

  // Same-cycle write to the read location forwards the new data.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (run_act && ren) begin
      if (wen && w_sel == r_sel) rd_dat_d = store_data;
      else                       rd_dat_d = mem_q[r_sel][ea];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_bank][mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= IDLE;
      drop_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      for (int i = 0; i < BANKS; i++) base_q[i] <= '0;
    end else begin
      mode_q    <= mode_d;
      drop_q    <= drop_d;
      rd_vld_q  <= run_act && ren;
      rd_dat_q  <= rd_dat_d;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_dat_q <= rd_dat_q;
      if (base_we) base_q[base_idx] <= base_val;
    end
  end

  assign CBG_to_LSU_bus = {out_vld_q, out_dat_q};
  assign mode           = mode_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_lsu_bank_responder.sv
// Bench for lsu_bank_responder: a request-level memory model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_lsu_bank_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init, run, host_we, base_we;
  logic [1:0]  host_bank, base_idx;
  logic [9:0]  host_addr, base_val;
  logic [31:0] host_wdata;
  logic [2:0]  R_request;
  logic [34:0] W_request;
  logic [11:0] LSU_addr_bus;
  logic [32:0] CBG_to_LSU_bus;
  logic [1:0]  mode;
  logic [15:0] drop_count;

  lsu_bank_responder dut (
    .clk(clk), .rst_n(rst_n), .init(init), .run(run),
    .host_we(host_we), .host_bank(host_bank), .host_addr(host_addr),
    .host_wdata(host_wdata), .base_we(base_we), .base_idx(base_idx),
    .base_val(base_val), .R_request(R_request), .W_request(W_request),
    .LSU_addr_bus(LSU_addr_bus), .CBG_to_LSU_bus(CBG_to_LSU_bus),
    .mode(mode), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;
  bit chk_en = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [4][1024];
  logic [9:0]  m_base [4];
  int          m_mode;
  logic [15:0] m_drop;
  logic [31:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Request-level model: mode 0 idle, 1 host, 2 run.
  always @(posedge clk) begin
    logic [9:0] ea;
    if (!rst_n) begin
      m_mode = 0;
      m_drop = 0;
      m_last = 0;
      for (int i = 0; i < 4; i++) m_base[i] = 0;
      q.delete();
    end else begin
      ea = m_base[LSU_addr_bus[11:10]] + LSU_addr_bus[9:0];
      if (m_mode == 2) begin
        if (W_request[32]) m_mem[W_request[34:33]][ea] = W_request[31:0];
        if (R_request[0])
          q.push_back('{due: cyc + 2, d: m_mem[R_request[2:1]][ea]});
      end else if ((R_request[0] || W_request[32]) && m_drop != 16'hFFFF) begin
        m_drop = m_drop + 1;
      end
      if (m_mode == 1 && host_we) m_mem[host_bank][host_addr] = host_wdata;
      if (base_we) m_base[base_idx] = base_val;
      if (init)     m_mode = 1;
      else if (run) m_mode = 2;
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit exp_v;
    if (chk_en) begin
      exp_v = (q.size() > 0 && q[0].due == cyc);
      if (exp_v) begin
        m_last = q[0].d;
        void'(q.pop_front());
      end
      chk("m_valid", {31'd0, CBG_to_LSU_bus[32]}, {31'd0, exp_v});
      chk("m_data", CBG_to_LSU_bus[31:0], m_last);
      chk("m_mode", {30'd0, mode}, m_mode);
      chk("m_drop", {16'd0, drop_count}, {16'd0, m_drop});
    end
    if (CBG_to_LSU_bus[32] === 1'b1) vcount++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    init = 0; run = 0; host_we = 0; base_we = 0;
    host_bank = 0; host_addr = 0; host_wdata = 0;
    base_idx = 0; base_val = 0;
    R_request = 0; W_request = 0; LSU_addr_bus = 0;
  endtask

  task automatic rd_chk(input logic [1:0] rs, input logic [1:0] as,
                        input logic [9:0] a, input logic [31:0] exp,
                        input string nm);
    step();
    R_request    = {rs, 1'b1};
    LSU_addr_bus = {as, a};
    step();
    clr();
    @(negedge clk);
    chk({nm, "_early"}, {31'd0, CBG_to_LSU_bus[32]}, 0);
    step();
    @(negedge clk);
    chk({nm, "_vld"}, {31'd0, CBG_to_LSU_bus[32]}, 1);
    chk({nm, "_dat"}, CBG_to_LSU_bus[31:0], exp);
    step();
    @(negedge clk);
    chk({nm, "_late"}, {31'd0, CBG_to_LSU_bus[32]}, 0);
    chk({nm, "_hold"}, CBG_to_LSU_bus[31:0], exp);
  endtask

  task automatic host_wr(input logic [1:0] b, input logic [9:0] a,
                         input logic [31:0] d);
    step();
    host_we = 1; host_bank = b; host_addr = a; host_wdata = d;
    step();
    clr();
  endtask

  initial begin
    rst_n = 0;
    clr();
    step();
    step();
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_bus", CBG_to_LSU_bus[31:0], 0);
    chk("rst_drop", {16'd0, drop_count}, 0);

    // Requests while idle only bump the drop counter.
    step();
    R_request = 3'b001;
    step();
    step();
    step();
    R_request = 0;
    @(negedge clk);
    chk("drop3", {16'd0, drop_count}, 3);
    step();
    R_request = 3'b001;
    for (int i = 0; i < 65531; i++) step();
    step();
    R_request = 0;
    @(negedge clk);
    chk("drop_max", {16'd0, drop_count}, 32'hFFFF);
    step();
    W_request = {2'd0, 1'b1, 32'h0};
    step();
    W_request = 0;
    @(negedge clk);
    chk("drop_sat", {16'd0, drop_count}, 32'hFFFF);

    step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rst2_drop", {16'd0, drop_count}, 0);

    step();
    init = 1;
    step();
    clr();
    @(negedge clk);
    chk("host_mode", {30'd0, mode}, 1);
    host_wr(2, 5, 32'hA5A5_0001);
    for (int i = 0; i < 8; i++) host_wr(3, 10'(i), 32'h3000_0000 + i);

    step();
    run = 1;
    step();
    clr();
    @(negedge clk);
    chk("run_mode", {30'd0, mode}, 2);
    rd_chk(2, 0, 5, 32'hA5A5_0001, "host_rd");

    // Base near the top of the bank wraps the effective address.
    step();
    base_we = 1; base_idx = 1; base_val = 10'h3FE;
    step();
    clr();
    W_request    = {2'd1, 1'b1, 32'h0000_1234};
    LSU_addr_bus = {2'd1, 10'd3};
    rd_chk(1, 1, 3, 32'h0000_1234, "wrap_rd");
    rd_chk(1, 0, 1, 32'h0000_1234, "wrap_ea");

    step();
    R_request    = {2'd0, 1'b1};
    W_request    = {2'd0, 1'b1, 32'hDEAD_BEEF};
    LSU_addr_bus = {2'd0, 10'd7};
    step();
    clr();
    step();
    @(negedge clk);
    chk("wfirst_vld", {31'd0, CBG_to_LSU_bus[32]}, 1);
    chk("wfirst_dat", CBG_to_LSU_bus[31:0], 32'hDEAD_BEEF);

    step();
    R_request    = {2'd2, 1'b1};
    LSU_addr_bus = {2'd2, 10'd5};
    base_we = 1; base_idx = 2; base_val = 10'h010;
    step();
    clr();
    step();
    @(negedge clk);
    chk("oldbase_dat", CBG_to_LSU_bus[31:0], 32'hA5A5_0001);

    step();
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      R_request    = {2'd3, 1'b1};
      LSU_addr_bus = {2'd0, 10'(i)};
      step();
    end
    clr();
    step(); step(); step();
    chk("stream8", vcount, 8);

    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      R_request    = {2'd3, 1'b1};
      LSU_addr_bus = {2'd0, 10'(i)};
      init         = (i == 5);
      step();
    end
    clr();
    step(); step(); step();
    chk("stream_init", vcount, 6);
    chk("stream_drop", {16'd0, drop_count}, 2);
    chk("stream_mode", {30'd0, mode}, 1);

    // Host writes are ignored once running.
    step();
    run = 1;
    step();
    clr();
    host_wr(0, 7, 32'h0000_0055);
    rd_chk(0, 0, 7, 32'hDEAD_BEEF, "host_in_run");

    step();
    R_request    = {2'd1, 1'b1};
    LSU_addr_bus = {2'd0, 10'd1};
    step();
    clr();
    rst_n = 0;
    step();
    rst_n = 1;
    vcount = 0;
    step(); step(); step();
    chk("rst_flight", vcount, 0);
    chk("rst_mode2", {30'd0, mode}, 0);
    step();
    run = 1;
    step();
    clr();
    rd_chk(1, 1, 1, 32'h0000_1234, "base_reset");

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
